// File: rtl/a2d_resp_pkg.sv
// Shared A2D definitions: SPI responder state encoding, frame geometry and
// the saturating bit-counter helper.
package a2d_resp_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int FRM_LEN = 16;
    localparam int CH_HI   = 13;
    localparam int CH_LO   = 11;
    localparam int RES_W   = 12;
    localparam int CNT_W   = 5;
    localparam int CNT_SAT = FRM_LEN + 1;

    // Stops at one past a full frame so an over-long frame can never alias to 16.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(CNT_SAT)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/a2d_resp_edge_det.sv
// Two-flop synchronizer plus history flop; flags single-clk rise/fall of an
// asynchronous input. All flops preset high to match idle-high SPI lines.
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic synced,
    output logic rise,
    output logic fall
);

    logic ff1, ff2, hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1  <= 1'b1;
            ff2  <= 1'b1;
            hist <= 1'b1;
        end else begin
            ff1  <= raw;
            ff2  <= ff1;
            hist <= ff2;
        end
    end

    assign synced = ff2;
    assign rise   = ff2 & ~hist;
    assign fall   = ~ff2 & hist;

endmodule

// File: rtl/a2d_resp.sv
// SPI slave model of an A2D converter: accepts a 16-bit command, reports the
// channel field, and returns the conversion result MSB-first on MISO.
module a2d_resp
    import a2d_resp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [RES_W-1:0] tx_data,
    output logic [2:0]       chnnl,
    output logic             cmd_rdy,
    output logic             frm_err
);

    logic ss_s, ss_rise, ss_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_ff1, mosi_s;

    state_t             state;
    logic [FRM_LEN-1:0] rx_shft;
    logic [FRM_LEN-1:0] tx_shft;
    logic [CNT_W-1:0]   bit_cnt;

    spi_edge_det u_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (SS_n),
        .synced (ss_s),
        .rise   (ss_rise),
        .fall   (ss_fall)
    );

    spi_edge_det u_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (SCLK),
        .synced (sclk_s),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    // Same depth as the SCLK path so MOSI is sampled alongside its rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_ff1 <= 1'b0;
            mosi_s   <= 1'b0;
        end else begin
            mosi_ff1 <= MOSI;
            mosi_s   <= mosi_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rx_shft <= '0;
            tx_shft <= '0;
            bit_cnt <= '0;
            chnnl   <= '0;
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_shft <= {4'h0, tx_data};
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // End of frame wins over a coincident SCLK edge.
                    if (ss_rise) begin
                        if (bit_cnt == CNT_W'(FRM_LEN)) begin
                            chnnl   <= rx_shft[CH_HI:CH_LO];
                            cmd_rdy <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shft <= {rx_shft[FRM_LEN-2:0], mosi_s};
                        bit_cnt <= cnt_inc(bit_cnt);
                    end else if (sclk_fall && bit_cnt != '0) begin
                        tx_shft <= {tx_shft[FRM_LEN-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MISO = ~ss_s & tx_shft[FRM_LEN-1];

    logic unused_ok;
    assign unused_ok = &{1'b0, rx_shft[FRM_LEN-1], sclk_s};

endmodule

// File: tb/tb_a2d_resp.sv
// Bench for a2d_resp: a behavioural A2D SPI master drives table vectors,
// hand-built corner sequences and random frames against a frame-level model.
module tb_a2d_resp;

    localparam int HALF = 4;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] tx;
        int          n;
        int          chg_at;
        logic [11:0] chg_tx;
        logic [2:0]  exp_ch;
        bit          exp_cmd;
        bit          exp_err;
        logic [15:0] exp_word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n, SCLK, MOSI;
    logic        MISO;
    logic [11:0] tx_data;
    logic [2:0]  chnnl;
    logic        cmd_rdy, frm_err;

    int nvec = 0;
    int nmis = 0;

    a2d_resp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .chnnl   (chnnl),
        .cmd_rdy (cmd_rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(negedge clk);
    endtask

    // MISO bits the master should see: the 16-bit word MSB-first, zeros after it.
    function automatic logic [31:0] exp_stream(input logic [15:0] word, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++)
            r = {r[30:0], (i < 16) ? word[15-i] : 1'b0};
        return r;
    endfunction

    task automatic shift_bits(input logic [15:0] cmd, input int n, input int chg_at,
                              input logic [11:0] chg_tx, output logic [31:0] stream);
        stream = '0;
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            if (i == chg_at) tx_data = chg_tx;
            wait_clk(HALF);
            SCLK = 1'b1;
            stream = {stream[30:0], MISO};
            wait_clk(HALF);
        end
    endtask

    task automatic watch(output int ncmd, output int nerr, output int nboth, output int pos);
        ncmd = 0; nerr = 0; nboth = 0; pos = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (cmd_rdy) begin ncmd++; pos = k; end
            if (frm_err) nerr++;
            if (cmd_rdy && frm_err) nboth++;
        end
    endtask

    task automatic frame(input logic [2:0] ch, input int n, input int chg_at, input logic [11:0] chg_tx,
                         output logic [31:0] stream, output int ncmd, output int nerr,
                         output int nboth, output int pos);
        @(negedge clk);
        SS_n = 1'b0;
        wait_clk(HALF);
        shift_bits({2'b00, ch, 11'h000}, n, chg_at, chg_tx, stream);
        SS_n = 1'b1;
        watch(ncmd, nerr, nboth, pos);
    endtask

    task automatic check_frame(input string tag, input logic [2:0] exp_ch, input bit exp_cmd,
                               input bit exp_err, input logic [15:0] word, input int n,
                               input logic [31:0] stream, input int ncmd, input int nerr,
                               input int nboth, input int pos);
        chk({tag, ".chnnl"}, 32'(chnnl), 32'(exp_ch));
        chk({tag, ".cmd_rdy_cnt"}, ncmd, exp_cmd ? 1 : 0);
        chk({tag, ".frm_err_cnt"}, nerr, exp_err ? 1 : 0);
        chk({tag, ".both"}, nboth, 0);
        chk({tag, ".miso"}, stream, exp_stream(word, n));
        if (exp_cmd) chk({tag, ".cmd_lat"}, pos, 3);
    endtask

    vec_t        tbl[10];
    logic [2:0]  cur_ch;
    logic [31:0] stream;
    int          ncmd, nerr, nboth, pos;

    initial begin
        //           ch      tx      n   chg  chg_tx  exp_ch  cmd err word
        tbl[0] = '{3'b010, 12'h000, 16, -1, 12'h000, 3'b010, 1, 0, 16'h0000};
        tbl[1] = '{3'b010, 12'hA5C, 16, -1, 12'h000, 3'b010, 1, 0, 16'h0A5C};
        tbl[2] = '{3'b010, 12'hA5C, 16, -1, 12'h000, 3'b010, 1, 0, 16'h0A5C};
        tbl[3] = '{3'b011, 12'h3C3, 16, -1, 12'h000, 3'b011, 1, 0, 16'h03C3};
        tbl[4] = '{3'b111, 12'h3C3, 16, -1, 12'h000, 3'b111, 1, 0, 16'h03C3};
        tbl[5] = '{3'b000, 12'h555,  9, -1, 12'h000, 3'b111, 0, 1, 16'h0555};
        tbl[6] = '{3'b001, 12'h555, 16, -1, 12'h000, 3'b001, 1, 0, 16'h0555};
        tbl[7] = '{3'b110, 12'h123, 16,  5, 12'hFFF, 3'b110, 1, 0, 16'h0123};
        tbl[8] = '{3'b100, 12'h0F0, 17, -1, 12'h000, 3'b110, 0, 1, 16'h00F0};
        tbl[9] = '{3'b101, 12'hFFF,  0, -1, 12'h000, 3'b110, 0, 1, 16'h0FFF};

        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; tx_data = '0;
        wait_clk(3);
        chk("rst.chnnl", 32'(chnnl), 0);
        chk("rst.miso", 32'(MISO), 0);
        chk("rst.flags", {cmd_rdy, frm_err}, 0);
        rst_n = 1'b1;
        wait_clk(3);

        for (int v = 0; v < 10; v++) begin
            tx_data = tbl[v].tx;
            frame(tbl[v].ch, tbl[v].n, tbl[v].chg_at, tbl[v].chg_tx, stream, ncmd, nerr, nboth, pos);
            check_frame($sformatf("tbl%0d", v), tbl[v].exp_ch, tbl[v].exp_cmd, tbl[v].exp_err,
                        tbl[v].exp_word, tbl[v].n, stream, ncmd, nerr, nboth, pos);
        end
        cur_ch = 3'b110;

        // SCLK activity with SS_n high must be ignored.
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; wait_clk(HALF);
            SCLK = 1'b1; wait_clk(HALF);
        end
        watch(ncmd, nerr, nboth, pos);
        chk("idle_sclk.chnnl", 32'(chnnl), 32'(cur_ch));
        chk("idle_sclk.pulses", ncmd + nerr, 0);

        // SS_n rise lands with the 16th SCLK rise: that rise is not counted.
        tx_data = 12'h321;
        @(negedge clk); SS_n = 1'b0; wait_clk(HALF);
        shift_bits({2'b00, 3'b011, 11'h000}, 15, -1, 12'h000, stream);
        SCLK = 1'b0; MOSI = 1'b0; wait_clk(HALF);
        SCLK = 1'b1; SS_n = 1'b1;
        watch(ncmd, nerr, nboth, pos);
        check_frame("coincide", cur_ch, 0, 1, 16'h0321, 15, stream, ncmd, nerr, nboth, pos);

        // Reset in the middle of a frame.
        tx_data = 12'hABC;
        @(negedge clk); SS_n = 1'b0; wait_clk(HALF);
        shift_bits({2'b00, 3'b010, 11'h000}, 8, -1, 12'h000, stream);
        rst_n = 1'b0;
        #1;
        chk("midrst.chnnl", 32'(chnnl), 0);
        chk("midrst.miso", 32'(MISO), 0);
        chk("midrst.flags", {cmd_rdy, frm_err}, 0);
        @(negedge clk); SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        wait_clk(4); rst_n = 1'b1; wait_clk(4);
        cur_ch = 3'b000;
        tx_data = 12'h5A5;
        frame(3'b101, 16, -1, 12'h000, stream, ncmd, nerr, nboth, pos);
        cur_ch = 3'b101;
        check_frame("postrst", cur_ch, 1, 0, 16'h05A5, 16, stream, ncmd, nerr, nboth, pos);

        // Random frames, mostly well-formed, some short/long.
        for (int r = 0; r < 25; r++) begin
            logic [2:0]  ch;
            logic [11:0] tx;
            int          n;
            bit          ok;
            ch = 3'($urandom);
            tx = 12'($urandom);
            n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : 16;
            ok = (n == 16);
            if (ok) cur_ch = ch;
            tx_data = tx;
            frame(ch, n, -1, 12'h000, stream, ncmd, nerr, nboth, pos);
            check_frame($sformatf("rnd%0d", r), cur_ch, ok, !ok, {4'h0, tx}, n,
                        stream, ncmd, nerr, nboth, pos);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
